// File: rtl/rf_write_arbiter.sv
// Shares the register-file write port between WB (priority) and a squashable mul/div FIFO.
// Writes appear one cycle after the grant edge; mul_ready drops when the FIFO is full; starved heads force a pipe stall.
module rf_write_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 16,
  parameter int FIFO_DEPTH = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_rd,
  input  logic [DATA_W-1:0]   wb_data,
  input  logic                mul_valid,
  output logic                mul_ready,
  input  logic [ADDR_W-1:0]   mul_rd,
  input  logic [DATA_W-1:0]   mul_data,
  output logic                rf_reg_write,
  output logic [ADDR_W-1:0]   rf_rd,
  output logic [DATA_W-1:0]   rf_write_data,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                pipe_stall,
  output logic [7:0]          squash_cnt,
  output logic                proto_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIM + 1);
  localparam int SQ_W  = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0]     ent_rd_q  [FIFO_DEPTH];
  logic [ADDR_W-1:0]     ent_rd_d  [FIFO_DEPTH];
  logic [DATA_W-1:0]     ent_dat_q [FIFO_DEPTH];
  logic [DATA_W-1:0]     ent_dat_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] ent_vld_q, ent_vld_d;
  logic [PTR_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [AGE_W-1:0]      age_q, age_d;
  logic                  stall_q, stall_d;
  logic [7:0]            sq_cnt_q, sq_cnt_d;
  logic                  err_q, err_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     wrd_q, wrd_d;
  logic [DATA_W-1:0]     wdat_q, wdat_d;

  logic            fifo_ne, wb_grant, pop, push, wb_in_rng, mul_in_rng;
  logic [SQ_W-1:0] sq_n;
  logic [8:0]      sq_sum;

  assign fifo_ne    = (count_q != '0);
  assign mul_ready  = (count_q < CNT_W'(FIFO_DEPTH));
  assign wb_in_rng  = (32'(wb_rd) < NUM_REGS);
  assign mul_in_rng = (32'(mul_rd) < NUM_REGS);
  // A stalled pipeline's wb_valid is ignored, so the head wins whenever stall is up.
  assign wb_grant   = wb_valid & ~stall_q;
  assign pop        = fifo_ne & ~wb_grant;
  assign push       = mul_valid & mul_ready;

  always_comb begin
    ent_rd_d  = ent_rd_q;
    ent_dat_d = ent_dat_q;
    ent_vld_d = ent_vld_q;
    head_d    = head_q;
    tail_d    = tail_q;
    we_d      = 1'b0;
    wrd_d     = wrd_q;
    wdat_d    = wdat_q;
    err_d     = err_q;
    sq_n      = '0;

    if (wb_valid && stall_q) err_d = 1'b1;

    if (wb_grant) begin
      if (wb_in_rng) begin
        we_d   = 1'b1;
        wrd_d  = wb_rd;
        wdat_d = wb_data;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          if (ent_vld_q[e] && (ent_rd_q[e] == wb_rd)) begin
            ent_vld_d[e] = 1'b0;
            sq_n         = sq_n + SQ_W'(1);
          end
        end
      end else begin
        err_d = 1'b1;
      end
    end else if (pop) begin
      if (ent_vld_q[head_q]) begin
        we_d   = 1'b1;
        wrd_d  = ent_rd_q[head_q];
        wdat_d = ent_dat_q[head_q];
      end
      ent_vld_d[head_q] = 1'b0;
      head_d            = head_q + 1'b1;
    end

    // Push after the squash loop so a same-edge entry with a matching rd survives.
    if (push) begin
      ent_rd_d[tail_q]  = mul_rd;
      ent_dat_d[tail_q] = mul_data;
      ent_vld_d[tail_q] = mul_in_rng;
      tail_d            = tail_q + 1'b1;
      if (!mul_in_rng) err_d = 1'b1;
    end

    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    sq_sum   = {1'b0, sq_cnt_q} + 9'(sq_n);
    sq_cnt_d = sq_sum[8] ? 8'hFF : sq_sum[7:0];
    age_d    = (fifo_ne && !pop) ? age_q + 1'b1 : '0;
    stall_d  = !stall_q && (age_d == AGE_W'(STARVE_LIM));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        ent_rd_q[e]  <= '0;
        ent_dat_q[e] <= '0;
      end
      ent_vld_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      age_q     <= '0;
      stall_q   <= 1'b0;
      sq_cnt_q  <= '0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
      wrd_q     <= '0;
      wdat_q    <= '0;
    end else begin
      ent_rd_q  <= ent_rd_d;
      ent_dat_q <= ent_dat_d;
      ent_vld_q <= ent_vld_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      age_q     <= age_d;
      stall_q   <= stall_d;
      sq_cnt_q  <= sq_cnt_d;
      err_q     <= err_d;
      we_q      <= we_d;
      wrd_q     <= wrd_d;
      wdat_q    <= wdat_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      for (int e = 0; e < FIFO_DEPTH; e++) begin
        if (ent_vld_q[e] && (ent_rd_q[e] == ADDR_W'(r))) busy_mask[r] = 1'b1;
      end
    end
  end

  assign rf_reg_write  = we_q;
  assign rf_rd         = wrd_q;
  assign rf_write_data = wdat_q;
  assign pipe_stall    = stall_q;
  assign squash_cnt    = sq_cnt_q;
  assign proto_err     = err_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus random traffic against a queue-based model.
module tb_rf_write_arbiter;
  localparam int DATA_W = 32, ADDR_W = 5, NUM_REGS = 16, FIFO_DEPTH = 2, STARVE_LIM = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic wb_valid = 1'b0, mul_valid = 1'b0, mul_ready;
  logic [ADDR_W-1:0] wb_rd = '0, mul_rd = '0, rf_rd;
  logic [DATA_W-1:0] wb_data = '0, mul_data = '0, rf_write_data;
  logic rf_reg_write, pipe_stall, proto_err;
  logic [NUM_REGS-1:0] busy_mask;
  logic [7:0] squash_cnt;

  rf_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS),
                     .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIM(STARVE_LIM)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_rd(mul_rd), .mul_data(mul_data),
    .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .busy_mask(busy_mask), .pipe_stall(pipe_stall), .squash_cnt(squash_cnt), .proto_err(proto_err));

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] rd; logic [DATA_W-1:0] data; bit live; } ent_t;
  ent_t q[$];
  bit m_stall, m_err, m_we, m_pushed;
  int m_age, m_sq;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_data;
  int n_checks = 0, n_pass = 0;

  task automatic model_reset();
    q.delete();
    m_stall = 0; m_err = 0; m_we = 0; m_pushed = 0; m_age = 0; m_sq = 0; m_rd = '0; m_data = '0;
  endtask

  // Applies the arbitration rules for one edge using the inputs currently driven.
  task automatic model_edge();
    bit stall_now, take_wb, pop;
    int sz, sq;
    ent_t e;
    stall_now = m_stall; sz = q.size(); sq = 0;
    m_pushed = 0; m_we = 0;
    if (wb_valid && stall_now) m_err = 1;
    take_wb = wb_valid && !stall_now;
    pop = (sz > 0) && (stall_now || !take_wb);
    if (take_wb) begin
      if (wb_rd < NUM_REGS) begin
        m_we = 1; m_rd = wb_rd; m_data = wb_data;
        foreach (q[i]) if (q[i].live && q[i].rd == wb_rd) begin q[i].live = 0; sq++; end
      end else m_err = 1;
    end else if (pop) begin
      e = q.pop_front();
      if (e.live) begin m_we = 1; m_rd = e.rd; m_data = e.data; end
    end
    m_sq = (m_sq + sq > 255) ? 255 : m_sq + sq;
    if (sz > 0 && !pop) m_age++; else m_age = 0;
    m_stall = stall_now ? 0 : (m_age == STARVE_LIM);
    if (mul_valid && sz < FIFO_DEPTH) begin
      e.rd = mul_rd; e.data = mul_data; e.live = (mul_rd < NUM_REGS);
      if (!e.live) m_err = 1;
      q.push_back(e);
      m_pushed = 1;
    end
  endtask

  function automatic logic [NUM_REGS-1:0] model_busy();
    logic [NUM_REGS-1:0] b;
    b = '0;
    foreach (q[i]) if (q[i].live) b[int'(q[i].rd)] = 1'b1;
    return b;
  endfunction

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid = 0; mul_valid = 0; wb_rd = '0; mul_rd = '0; wb_data = '0; mul_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0; model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, busy_mask, pipe_stall, squash_cnt, proto_err, mul_ready} !==
        {1'b0, 5'd0, 32'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1})
      $display("FAIL reset_state: got we=%b rd=%0d data=%h busy=%h stall=%b sq=%0d err=%b rdy=%b, want all 0 and rdy=1",
               rf_reg_write, rf_rd, rf_write_data, busy_mask, pipe_stall, squash_cnt, proto_err, mul_ready);
    else n_pass++;
    rst_n = 1;
    tick();
    n_checks++;
    if (rf_reg_write !== 1'b0) $display("FAIL reset_idle_write: got %b want 0", rf_reg_write); else n_pass++;
  endtask

  task automatic test_wb_only();
    wb_valid = 1; wb_rd = 5'd2; wb_data = 32'h6;
    tick();
    wb_valid = 0;
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b1, 5'd2, 32'h6})
      $display("FAIL wb_write: got we=%b rd=%0d data=%h want 1/2/6", rf_reg_write, rf_rd, rf_write_data);
    else n_pass++;
    tick();
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b0, 5'd2, 32'h6})
      $display("FAIL wb_hold: got we=%b rd=%0d data=%h want 0/2/6", rf_reg_write, rf_rd, rf_write_data);
    else n_pass++;
  endtask

  task automatic test_mul_only();
    mul_valid = 1; mul_rd = 5'd5; mul_data = 32'h964EB;
    tick();
    mul_valid = 0;
    n_checks++;
    if ({rf_reg_write, busy_mask} !== {1'b0, 16'h0020})
      $display("FAIL mul_pushed: got we=%b busy=%h want 0/0020", rf_reg_write, busy_mask);
    else n_pass++;
    tick();
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, busy_mask} !== {1'b1, 5'd5, 32'h964EB, 16'h0})
      $display("FAIL mul_write: got we=%b rd=%0d data=%h busy=%h want 1/5/964eb/0", rf_reg_write, rf_rd, rf_write_data, busy_mask);
    else n_pass++;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'hA;
    mul_valid = 1; mul_rd = 5'd9; mul_data = 32'h1;
    tick();
    mul_rd = 5'd10; mul_data = 32'h2;
    tick();
    mul_valid = 0; wb_valid = 0;
    n_checks++;
    if ({mul_ready, busy_mask} !== {1'b0, 16'h0600})
      $display("FAIL fifo_full: got rdy=%b busy=%h want 0/0600", mul_ready, busy_mask);
    else n_pass++;
    tick();
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, mul_ready} !== {1'b1, 5'd9, 32'h1, 1'b1})
      $display("FAIL drain_first: got we=%b rd=%0d data=%h rdy=%b want 1/9/1/1", rf_reg_write, rf_rd, rf_write_data, mul_ready);
    else n_pass++;
    tick();
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, busy_mask} !== {1'b1, 5'd10, 32'h2, 16'h0})
      $display("FAIL drain_second: got we=%b rd=%0d data=%h busy=%h want 1/10/2/0", rf_reg_write, rf_rd, rf_write_data, busy_mask);
    else n_pass++;
  endtask

  task automatic test_starvation();
    mul_valid = 1; mul_rd = 5'd7; mul_data = 32'h77;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h100;
    tick();
    mul_valid = 0;
    for (int i = 1; i <= STARVE_LIM; i++) begin
      wb_data = 32'h100 + 32'(i);
      tick();
      n_checks++;
      if (pipe_stall !== 1'(i == STARVE_LIM))
        $display("FAIL starve_stall_%0d: got %b want %b", i, pipe_stall, (i == STARVE_LIM));
      else n_pass++;
    end
    wb_valid = 0;
    tick();
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, pipe_stall, proto_err} !== {1'b1, 5'd7, 32'h77, 1'b0, 1'b0})
      $display("FAIL forced_pop: got we=%b rd=%0d data=%h stall=%b err=%b want 1/7/77/0/0",
               rf_reg_write, rf_rd, rf_write_data, pipe_stall, proto_err);
    else n_pass++;
    wb_valid = 1; wb_rd = 5'd3; wb_data = 32'h33;
    tick();
    wb_valid = 0;
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b1, 5'd3, 32'h33})
      $display("FAIL wb_resume: got we=%b rd=%0d data=%h want 1/3/33", rf_reg_write, rf_rd, rf_write_data);
    else n_pass++;
  endtask

  task automatic test_squash();
    mul_valid = 1; mul_rd = 5'd8; mul_data = 32'h113D4;
    tick();
    mul_valid = 0;
    wb_valid = 1; wb_rd = 5'd8; wb_data = 32'h1;
    tick();
    wb_valid = 0;
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, squash_cnt, busy_mask} !== {1'b1, 5'd8, 32'h1, 8'd1, 16'h0})
      $display("FAIL squash_wb: got we=%b rd=%0d data=%h sq=%0d busy=%h want 1/8/1/1/0",
               rf_reg_write, rf_rd, rf_write_data, squash_cnt, busy_mask);
    else n_pass++;
    tick();
    n_checks++;
    if ({rf_reg_write, rf_write_data, mul_ready} !== {1'b0, 32'h1, 1'b1})
      $display("FAIL squash_drop: got we=%b data=%h rdy=%b want 0/1/1", rf_reg_write, rf_write_data, mul_ready);
    else n_pass++;
    wb_valid = 1; wb_rd = 5'd6; wb_data = 32'hAA;
    mul_valid = 1; mul_rd = 5'd6; mul_data = 32'hBB;
    tick();
    wb_valid = 0; mul_valid = 0;
    n_checks++;
    if ({busy_mask, squash_cnt} !== {16'h0040, 8'd1})
      $display("FAIL younger_kept: got busy=%h sq=%0d want 0040/1", busy_mask, squash_cnt);
    else n_pass++;
    tick();
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data} !== {1'b1, 5'd6, 32'hBB})
      $display("FAIL younger_write: got we=%b rd=%0d data=%h want 1/6/bb", rf_reg_write, rf_rd, rf_write_data);
    else n_pass++;
  endtask

  task automatic test_random();
    bit pend;
    pend = 0;
    for (int c = 0; c < 400; c++) begin
      if (!pend && $urandom_range(0, 1) == 1) begin
        pend = 1;
        mul_rd = ($urandom_range(0, 63) == 0) ? 5'd20 : 5'($urandom_range(0, 3));
        mul_data = $urandom;
      end
      mul_valid = pend;
      wb_valid = !m_stall && ($urandom_range(0, 2) != 0);
      wb_rd = ($urandom_range(0, 63) == 0) ? 5'd25 : 5'($urandom_range(0, 3));
      wb_data = $urandom;
      tick();
      if (m_pushed) pend = 0;
      n_checks++;
      if ({rf_reg_write, rf_rd, rf_write_data} !== {m_we, m_rd, m_data})
        $display("FAIL rand_port c%0d: got we=%b rd=%0d data=%h want %b/%0d/%h", c, rf_reg_write, rf_rd, rf_write_data, m_we, m_rd, m_data);
      else n_pass++;
      n_checks++;
      if (busy_mask !== model_busy()) $display("FAIL rand_busy c%0d: got %h want %h", c, busy_mask, model_busy()); else n_pass++;
      n_checks++;
      if ({pipe_stall, mul_ready} !== {m_stall, 1'(q.size() < FIFO_DEPTH)})
        $display("FAIL rand_stall_rdy c%0d: got %b/%b want %b/%b", c, pipe_stall, mul_ready, m_stall, (q.size() < FIFO_DEPTH));
      else n_pass++;
      n_checks++;
      if ({squash_cnt, proto_err} !== {8'(m_sq), m_err})
        $display("FAIL rand_sq_err c%0d: got %0d/%b want %0d/%b", c, squash_cnt, proto_err, m_sq, m_err);
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_errors();
    do_reset();
    wb_valid = 1; wb_rd = 5'd20; wb_data = 32'hDEAD;
    tick();
    wb_valid = 0;
    n_checks++;
    if ({rf_reg_write, proto_err} !== {1'b0, 1'b1})
      $display("FAIL wb_out_of_range: got we=%b err=%b want 0/1", rf_reg_write, proto_err);
    else n_pass++;
    do_reset();
    mul_valid = 1; mul_rd = 5'd7; mul_data = 32'h70;
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h11;
    tick();
    mul_valid = 0;
    repeat (STARVE_LIM) tick();
    n_checks++;
    if ({pipe_stall, proto_err} !== {1'b1, 1'b0})
      $display("FAIL err_pre_stall: got stall=%b err=%b want 1/0", pipe_stall, proto_err);
    else n_pass++;
    wb_rd = 5'd2; wb_data = 32'h55;
    tick();
    wb_valid = 0;
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, proto_err, busy_mask} !== {1'b1, 5'd7, 32'h70, 1'b1, 16'h0})
      $display("FAIL wb_during_stall: got we=%b rd=%0d data=%h err=%b busy=%h want 1/7/70/1/0",
               rf_reg_write, rf_rd, rf_write_data, proto_err, busy_mask);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    wb_valid = 1; wb_rd = 5'd1; wb_data = 32'h1;
    mul_valid = 1; mul_rd = 5'd3; mul_data = 32'h3;
    tick();
    mul_rd = 5'd4; mul_data = 32'h4;
    tick();
    mul_valid = 0;
    repeat (STARVE_LIM - 1) tick();
    wb_valid = 0;
    n_checks++;
    if ({pipe_stall, mul_ready, busy_mask} !== {1'b1, 1'b0, 16'h0018})
      $display("FAIL pre_reset_state: got stall=%b rdy=%b busy=%h want 1/0/0018", pipe_stall, mul_ready, busy_mask);
    else n_pass++;
    #2 rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if ({rf_reg_write, rf_rd, rf_write_data, busy_mask, pipe_stall, squash_cnt, proto_err, mul_ready} !==
        {1'b0, 5'd0, 32'd0, 16'd0, 1'b0, 8'd0, 1'b0, 1'b1})
      $display("FAIL async_reset: got we=%b rd=%0d data=%h busy=%h stall=%b sq=%0d err=%b rdy=%b, want all 0 and rdy=1",
               rf_reg_write, rf_rd, rf_write_data, busy_mask, pipe_stall, squash_cnt, proto_err, mul_ready);
    else n_pass++;
    #2 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if ({rf_reg_write, busy_mask, mul_ready} !== {1'b0, 16'h0, 1'b1})
        $display("FAIL post_reset_%0d: got we=%b busy=%h rdy=%b want 0/0/1", i, rf_reg_write, busy_mask, mul_ready);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_wb_only();
    test_mul_only();
    test_starvation();
    test_squash();
    test_random();
    test_errors();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port (rd / write_data / reg_write) between two producers:
  - the pipeline writeback stage, which has priority;
  - the multi-cycle multiply/divide unit, which is buffered in a small FIFO.
- Exports a per-register busy mask so decode can stall on pending writes.
- Raises a one-cycle pipeline stall when buffered results starve.
- Sits between the WB stage, the mul/div unit and the register file.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- NUM_REGS, 16, implemented registers; addresses >= NUM_REGS are out of range
- FIFO_DEPTH, 2, mul/div result buffer entries (power of 2, >= 2)
- STARVE_LIM, 4, cycles a FIFO head may wait before a forced slot

Ports:
- clk, input, 1: clock, all state on posedge
- rst_n, input, 1: asynchronous active-low reset
- wb_valid, input, 1: pipeline writeback request; no ready, must be accepted
- wb_rd, input, ADDR_W: pipeline destination register
- wb_data, input, DATA_W: pipeline result
- mul_valid, input, 1: mul/div result valid
- mul_ready, output, 1: FIFO can accept
- mul_rd, input, ADDR_W: mul/div destination register
- mul_data, input, DATA_W: mul/div result
- rf_reg_write, output, 1: register file write enable
- rf_rd, output, ADDR_W: register file write address
- rf_write_data, output, DATA_W: register file write data
- busy_mask, output, NUM_REGS: bit i = pending unsquashed FIFO write to reg i
- pipe_stall, output, 1: the pipeline must hold wb_valid=0 this cycle
- squash_cnt, output, 8: saturating count of squashed FIFO entries
- proto_err, output, 1: sticky protocol/address error

Behaviour:
- Reset (async, rst_n=0):
  - rf_reg_write=0, rf_rd=0, rf_write_data=0.
  - FIFO empty, all entry valid bits 0, busy_mask=0.
  - pipe_stall=0, age=0, squash_cnt=0, proto_err=0.
  - Reset mid-operation discards buffered results with no write.
- Write-port outputs are registered. A grant at edge n drives rf_reg_write=1 during cycle n+1; the register file commits on the negedge of that cycle. With no grant, rf_reg_write=0 and rf_rd/rf_write_data hold their last values.
- mul_ready = (count < FIFO_DEPTH), derived from registered state only.
  - A push happens at the edge when mul_valid & mul_ready.
  - A push and a pop in the same edge are legal.
  - mul_valid while mul_ready=0 is held by the producer; nothing is lost.
- Grant priority each edge:
  - (1) pipe_stall=1 and FIFO non-empty: FIFO head.
  - (2) wb_valid: WB.
  - (3) FIFO non-empty: FIFO head.
  - (4) none.
- Popping the head: a valid head produces a write; a squashed head is dropped silently. Either way the slot is freed and the edge counts as a grant for age purposes.
- Minimum mul latency is 2 cycles: push at edge n, pop at edge n+1 (earliest), write visible in cycle n+2. There is no bypass.
- Squash (WAW): when WB is granted and wb_rd matches any valid FIFO entry, those entries have their valid bit cleared at the same edge, and squash_cnt increments by the number of entries cleared.
  - A mul push in the same edge with the same rd is not squashed; it is younger.
- Two FIFO entries with the same rd both write, in FIFO order.
- busy_mask is recomputed from FIFO state after each edge. It reflects pushes, pops and squashes at that edge.
- Starvation:
  - age increments on each edge where the FIFO head exists and is not popped; it resets to 0 on a pop or when the FIFO is empty.
  - pipe_stall is registered: it is set at the edge where age reaches STARVE_LIM and cleared at the edge the forced pop happens.
  - wb_valid=1 while pipe_stall=1 is ignored (no write, no squash) and sets proto_err.
- Address range: a request with rd >= NUM_REGS is accepted but never written. A WB request is dropped at grant. A mul request is pushed as squashed and does not count in squash_cnt. Both cases set proto_err.
- rd=0 is a normal register; there is no hardwired zero.
- squash_cnt saturates at 255.

Test Plan:
- WB only: wb_valid=1, wb_rd=2, wb_data=32'h6 at edge 1 -> cycle 2: rf_reg_write=1, rf_rd=2, rf_write_data=6; cycle 3: rf_reg_write=0.
- Mul only:
  - mul_valid=1, rd=5, data=32'h964EB at edge 1 -> busy_mask[5]=1 after edge 1; write in cycle 3; busy_mask[5]=0 after edge 2.
  - Fill both entries -> mul_ready=0.
- Contention/starvation, STARVE_LIM=4: FIFO holds rd=7 and wb_valid=1 every cycle -> pipe_stall=1 after the 4th lost edge; the next write is rd=7; pipe_stall then clears; WB resumes.
- Squash: FIFO holds rd=8 (32'h113D4); wb rd=8, data=32'h1 -> only 32'h1 is written to rd 8; squash_cnt=1; busy_mask[8]=0; the squashed pop produces no write.
- Errors:
  - wb_rd=20 -> no write, proto_err=1.
  - wb_valid during pipe_stall -> ignored, proto_err=1.
- Async reset with 2 FIFO entries and pipe_stall=1 -> all outputs 0 immediately; after release mul_ready=1 and no stale writes appear.
